// File: rtl/midi_note_gate_controller.sv
// rtl/midi_note_gate_controller.sv - last-note-priority MIDI note stack driving an envelope gate
// Optional feature: define NOTE_GATE_RETRIGGER_EN to drop the gate for one cycle whenever the
// sounding note changes while the gate stays open; undefined gives legato behaviour.
module midi_note_gate_controller #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             event_valid,
  output logic                             event_ready,
  input  logic                             event_on,
  input  logic [6:0]                       event_note,
  input  logic [6:0]                       event_velocity,
  output logic                             gate,
  output logic [6:0]                       note,
  output logic [6:0]                       velocity,
  output logic [$clog2(STACK_DEPTH+1)-1:0] held_count,
  output logic                             overflow
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    UPDATE = 2'd2,
    RETRIG = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Stack entry 0 is the top (most recent); valid entries are packed from 0 upward.
  logic [6:0]             stk_note [STACK_DEPTH];
  logic [6:0]             stk_vel  [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] stk_valid;

  // Event captured at acceptance; a zero-velocity note-on is folded into a note-off here.
  logic       lat_on;
  logic [6:0] lat_note;
  logic [6:0] lat_vel;

  logic          match_hit;
  logic [IW-1:0] match_idx;
  logic          srch_hit;
  logic [IW-1:0] srch_idx;

  logic [6:0]             nxt_note [STACK_DEPTH];
  logic [6:0]             nxt_vel  [STACK_DEPTH];
  logic [STACK_DEPTH-1:0] nxt_valid;
  logic [CW-1:0]          nxt_count;
  logic                   nxt_ovf;
  logic                   retrig_take;

  // Holds event_ready low from reset until the first clock edge after release.
  logic ready_en;
  logic accept;

  assign event_ready = ready_en && (state == IDLE);
  assign accept      = event_valid && event_ready;

  // Parallel compare of the latched note against every valid entry; lowest index wins.
  always_comb begin
    srch_hit = 1'b0;
    srch_idx = '0;
    for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
      if (stk_valid[i] && (stk_note[i] == lat_note)) begin
        srch_hit = 1'b1;
        srch_idx = IW'(i);
      end
    end
  end

  // Next stack image applied at the UPDATE edge.
  always_comb begin
    int lim;
    nxt_note  = stk_note;
    nxt_vel   = stk_vel;
    nxt_valid = stk_valid;
    nxt_count = held_count;
    nxt_ovf   = 1'b0;
    lim       = match_hit ? int'(match_idx) : STACK_DEPTH - 1;
    if (lat_on) begin
      // Shift entries down through the match (or the whole stack), then place the note on top.
      // With no match on a full stack the bottom entry falls off the end.
      for (int i = 1; i < STACK_DEPTH; i++) begin
        if (i <= lim) begin
          nxt_note[i]  = stk_note[i-1];
          nxt_vel[i]   = stk_vel[i-1];
          nxt_valid[i] = stk_valid[i-1];
        end
      end
      nxt_note[0]  = lat_note;
      nxt_vel[0]   = lat_vel;
      nxt_valid[0] = 1'b1;
      if (!match_hit) begin
        if (held_count == CW'(STACK_DEPTH)) begin
          nxt_ovf = 1'b1;
        end else begin
          nxt_count = held_count + CW'(1);
        end
      end
    end else if (match_hit) begin
      // Close the gap left by the released note.
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        if (i >= lim) begin
          nxt_note[i]  = stk_note[i+1];
          nxt_vel[i]   = stk_vel[i+1];
          nxt_valid[i] = stk_valid[i+1];
        end
      end
      nxt_note[STACK_DEPTH-1]  = 7'd0;
      nxt_vel[STACK_DEPTH-1]   = 7'd0;
      nxt_valid[STACK_DEPTH-1] = 1'b0;
      nxt_count                = held_count - CW'(1);
    end
  end

`ifdef NOTE_GATE_RETRIGGER_EN
  // Retrigger only when the gate was open, stays open and the sounding note changes.
  assign retrig_take = gate && (nxt_count != '0) && (nxt_note[0] != stk_note[0]);
`else
  assign retrig_take = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH:  state_nxt = UPDATE;
      UPDATE:  state_nxt = retrig_take ? RETRIG : IDLE;
`ifdef NOTE_GATE_RETRIGGER_EN
      RETRIG:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: event latch, search result, stack and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en   <= 1'b0;
      lat_on     <= 1'b0;
      lat_note   <= 7'd0;
      lat_vel    <= 7'd0;
      match_hit  <= 1'b0;
      match_idx  <= '0;
      stk_valid  <= '0;
      held_count <= '0;
      gate       <= 1'b0;
      note       <= 7'd0;
      velocity   <= 7'd0;
      overflow   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stk_note[i] <= 7'd0;
        stk_vel[i]  <= 7'd0;
      end
    end else begin
      ready_en <= 1'b1;
      overflow <= 1'b0;
      if (accept) begin
        lat_on   <= event_on && (event_velocity != 7'd0);
        lat_note <= event_note;
        lat_vel  <= event_velocity;
      end
      if (state == SEARCH) begin
        match_hit <= srch_hit;
        match_idx <= srch_idx;
      end
      if (state == UPDATE) begin
        stk_note   <= nxt_note;
        stk_vel    <= nxt_vel;
        stk_valid  <= nxt_valid;
        held_count <= nxt_count;
        overflow   <= nxt_ovf;
        gate       <= (nxt_count != '0) && !retrig_take;
        // On release the last note and velocity stay on the outputs for the envelope tail.
        if (nxt_count != '0) begin
          note     <= nxt_note[0];
          velocity <= nxt_vel[0];
        end
      end
`ifdef NOTE_GATE_RETRIGGER_EN
      if (state == RETRIG) begin
        gate <= 1'b1;
      end
`endif
    end
  end

endmodule
